// File: rtl/pp_acc_pkg.sv
// Shared definitions for the partial-product group accumulator.
//  - Default LANES / PP_W / ACC_W values.
//  - Stage-2 FSM state encoding.
//  - Generic sign-extend helper.
//  - Per-bit transistor-count weights feeding the `number` metric outputs.
package pp_acc_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned PP_W_DEF  = 15;
  localparam int unsigned ACC_W_DEF = 22;

  localparam int unsigned TC_FA   = 28;  // full-adder cell, per bit
  localparam int unsigned TC_MUX2 = 12;  // 2:1 mux, per bit
  localparam int unsigned TC_DFF  = 24;  // flip-flop, per bit
  localparam int unsigned TC_XOR  = 12;  // overflow detect gate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  // Sign-extend the low w bits of v to 64 bits; callers cast down to their width.
  function automatic logic [63:0] sext64(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/pp_lane_sum.sv
// Combinational signed adder tree: sums LANES aligned partial products,
// each sign-extended from PP_W to ACC_W.
// Ports:
//  i_pp    in   LANES*PP_W  packed lanes, lane k = i_pp[k*PP_W +: PP_W]
//  o_sum   out  ACC_W       signed lane sum
//  number  out  51          transistor-count metric of this adder tree
module pp_lane_sum
  import pp_acc_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned PP_W  = PP_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [LANES*PP_W-1:0] i_pp,
  output logic [ACC_W-1:0]      o_sum,
  output logic [50:0]           number
);

  logic [ACC_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_sum = w_sum + ACC_W'(sext64(64'(i_pp[k*PP_W +: PP_W]), PP_W));
    end
  end

  assign o_sum  = w_sum;
  assign number = 51'((LANES - 1) * ACC_W * TC_FA);

endmodule

// File: rtl/pp_group_accumulator.sv
// Accumulates variable-length groups of aligned partial products (LANES per
// beat, group ended by i_last) into a signed ACC_W sum, presented with a
// valid/ready handshake. Stage 1 registers the lane sum, stage 2 is the
// accumulator FSM / output register. Both stages hold while the output stalls.
// Optional feature macro: ACC_SAT_EN -- saturating accumulate with sticky o_ovf;
// when undefined the accumulate wraps and o_ovf is constant 0.
// Ports:
//  i_clk, i_rst   clock (rising edge), async active-high reset
//  i_valid/o_ready  input beat handshake; i_pp lanes, i_last ends group
//  o_valid/i_ready  group result handshake; o_sum result, o_ovf overflow flag
//  number         summed transistor-count metric
module pp_group_accumulator
  import pp_acc_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned PP_W  = PP_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES*PP_W-1:0] i_pp,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ACC_W-1:0]      o_sum,
  output logic                  o_ovf,
  output logic [50:0]           number
);

  localparam logic [50:0] NUM_BASE =
    51'(ACC_W * TC_FA + 2 * ACC_W * TC_MUX2 + (2 * ACC_W + 4) * TC_DFF);

  logic [ACC_W-1:0] w_lane_sum;
  logic [50:0]      w_ls_number;
  logic             w_stall;
  logic             w_accept;
  logic             r_s1_valid;
  logic             r_s1_last;
  logic [ACC_W-1:0] r_s1_sum;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_add_res;
  logic             w_load;
  logic             w_add;
  acc_state_t       r_state;
  acc_state_t       w_state_nxt;

  pp_lane_sum #(
    .LANES (LANES),
    .PP_W  (PP_W),
    .ACC_W (ACC_W)
  ) u_lane_sum (
    .i_pp   (i_pp),
    .o_sum  (w_lane_sum),
    .number (w_ls_number)
  );

  assign w_stall  = o_valid & ~i_ready;
  assign o_ready  = ~w_stall;
  assign w_accept = i_valid & o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= w_lane_sum;
        r_s1_last <= i_last;
      end
    end
  end

  // HOLD with i_ready=1 is not a stall, so a waiting stage-1 beat loads the
  // next group in the same cycle the current result is taken.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    o_valid     = (r_state == HOLD);
    if (!w_stall) begin
      case (r_state)
        IDLE: if (r_s1_valid) begin
          w_load      = 1'b1;
          w_state_nxt = r_s1_last ? HOLD : ACCUM;
        end
        ACCUM: if (r_s1_valid) begin
          w_add = 1'b1;
          if (r_s1_last) w_state_nxt = HOLD;
        end
        HOLD: if (r_s1_valid) begin
          w_load      = 1'b1;
          w_state_nxt = r_s1_last ? HOLD : ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)     r_acc <= r_s1_sum;
      else if (w_add) r_acc <= w_add_res;
    end
  end

  assign o_sum = r_acc;

`ifdef ACC_SAT_EN
  logic [ACC_W:0] w_add_wide;
  logic           w_add_ovf;
  logic           r_ovf;

  // One guard bit: overflow when the two top bits of the widened sum differ.
  assign w_add_wide = {r_acc[ACC_W-1], r_acc} + {r_s1_sum[ACC_W-1], r_s1_sum};
  assign w_add_ovf  = w_add_wide[ACC_W] ^ w_add_wide[ACC_W-1];
  assign w_add_res  = !w_add_ovf ? w_add_wide[ACC_W-1:0]
                    : (w_add_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_ovf <= 1'b0;
    else if (w_load) r_ovf <= 1'b0;
    else if (w_add)  r_ovf <= r_ovf | w_add_ovf;
  end

  assign o_ovf  = r_ovf;
  assign number = w_ls_number + NUM_BASE + 51'(ACC_W * TC_MUX2 + TC_DFF + TC_XOR);
`else
  assign w_add_res = r_acc + r_s1_sum;
  assign o_ovf     = 1'b0;
  assign number    = w_ls_number + NUM_BASE;
`endif

endmodule

// File: tb/tb_pp_group_accumulator.sv
// Bench for pp_group_accumulator at ACC_W=18: directed group scenarios with
// literal expectations plus randomized groups, all checked each cycle against
// a queue-based group-sum model.
module tb_pp_group_accumulator;

  localparam int unsigned LANES = 4;
  localparam int unsigned PP_W  = 15;
  localparam int unsigned ACC_W = 18;
  localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W - 1));

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_valid;
  logic                  o_ready;
  logic [LANES*PP_W-1:0] i_pp;
  logic                  i_last;
  logic                  o_valid;
  logic                  i_ready;
  logic [ACC_W-1:0]      o_sum;
  logic                  o_ovf;
  logic [50:0]           number;

  always #5 clk = ~clk;

  pp_group_accumulator #(
    .LANES (LANES),
    .PP_W  (PP_W),
    .ACC_W (ACC_W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_pp    (i_pp),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_ovf   (o_ovf),
    .number  (number)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int          n_out = 0;
  int          n_groups = 0;
  bit          rdy_rand = 1'b0;

  typedef struct {
    longint      sum;
    bit          ovf;
    int unsigned rdy;
  } exp_t;
  exp_t   q[$];
  bit     in_grp = 1'b0;
  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic longint wrapv(input longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic logic [LANES*PP_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [LANES*PP_W-1:0] r;
    r = {PP_W'(d), PP_W'(c), PP_W'(b), PP_W'(a)};
    return r;
  endfunction

  function automatic longint sum_s(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Model: a group result becomes visible two cycles after its last beat is
  // taken, but never before the previous result has been consumed.
  always @(negedge clk) begin : mon
    bit                ev;
    longint            bs;
    logic [PP_W-1:0]   lane;
    cyc++;
    if (rst) begin
      q.delete();
      in_grp = 1'b0;
    end else begin
      ev = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("o_valid", longint'(o_valid), longint'(ev));
      if (ev) begin
        chk("o_sum", sum_s(o_sum), q[0].sum);
        chk("o_ovf", longint'(o_ovf), longint'(q[0].ovf));
      end
      chk("o_ready", longint'(o_ready), longint'(!(ev && !i_ready)));
      if (ev && i_ready) begin
        void'(q.pop_front());
        n_out++;
      end
      if (i_valid && !(ev && !i_ready)) begin
        bs = 0;
        for (int k = 0; k < int'(LANES); k++) begin
          lane = i_pp[k*PP_W +: PP_W];
          bs += longint'($signed(lane));
        end
        if (!in_grp) begin
          m_acc  = bs;
          m_ovf  = 1'b0;
          in_grp = 1'b1;
        end else begin
`ifdef ACC_SAT_EN
          m_acc += bs;
          if (m_acc > MAXV) begin
            m_acc = MAXV;
            m_ovf = 1'b1;
          end else if (m_acc < MINV) begin
            m_acc = MINV;
            m_ovf = 1'b1;
          end
`else
          m_acc = wrapv(m_acc + bs);
`endif
        end
        if (i_last) begin
          q.push_back('{sum: m_acc, ovf: m_ovf, rdy: cyc + 2});
          in_grp = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) i_ready = 1'($urandom_range(0, 1));
  end

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "aborting after handshake timeout");
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send_beat(input logic [LANES*PP_W-1:0] pp, input bit last);
    int g;
    g       = 0;
    i_valid = 1'b1;
    i_pp    = pp;
    i_last  = last;
    @(negedge clk);
    while (!o_ready && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!o_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: o_ready=%0d, required 1 within 200 cycles", o_ready);
      finish_now();
    end
    if (last) n_groups++;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    int gap;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_pp    = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;

    @(negedge clk);
    chk("rst_o_valid", longint'(o_valid), 0);
    chk("rst_o_sum", sum_s(o_sum), 0);
    chk("rst_o_ovf", longint'(o_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_ready", longint'(o_ready), 1);
    @(posedge clk); #1;

    // Reset in the middle of a group discards it.
    send_beat(pack4(1, 1, 1, 1), 1'b0);
    send_beat(pack4(1, 1, 1, 1), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_rst_valid", longint'(o_valid), 0);
    chk("t1_rst_sum", sum_s(o_sum), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat(pack4(2, 2, 2, 2), 1'b1);
    @(negedge clk);
    chk("t1_valid_t1", longint'(o_valid), 0);
    @(negedge clk);
    chk("t1_valid_t2", longint'(o_valid), 1);
    chk("t1_sum", sum_s(o_sum), 8);
    @(posedge clk); #1;

    // Signed mix.
    send_beat(pack4(16383, 0, 0, 0), 1'b0);
    send_beat(pack4(-3, -3, -3, -3), 1'b1);
    @(negedge clk);
    chk("t2_valid_t1", longint'(o_valid), 0);
    @(negedge clk);
    chk("t2_valid_t2", longint'(o_valid), 1);
    chk("t2_sum", sum_s(o_sum), 16371);
    @(posedge clk); #1;

    // Back-to-back single-beat groups.
    send_beat(pack4(5, 0, 0, 0), 1'b1);
    send_beat(pack4(-7, 0, 0, 0), 1'b1);
    @(negedge clk);
    chk("t3_a_valid", longint'(o_valid), 1);
    chk("t3_a_sum", sum_s(o_sum), 5);
    @(negedge clk);
    chk("t3_b_valid", longint'(o_valid), 1);
    chk("t3_b_sum", sum_s(o_sum), -7);
    @(posedge clk); #1;
    idle(2);

    // Backpressure: result frozen, third beat held until release.
    i_ready = 1'b0;
    send_beat(pack4(1, 2, 3, 4), 1'b1);
    send_beat(pack4(1, 1, 1, 1), 1'b1);
    i_valid = 1'b1;
    i_pp    = pack4(0, 0, 0, 9);
    i_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", longint'(o_valid), 1);
      chk("t4_hold_sum", sum_s(o_sum), 10);
      chk("t4_hold_ready", longint'(o_ready), 0);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    send_beat(pack4(0, 0, 0, 9), 1'b1);
    @(negedge clk);
    chk("t4_b_sum", sum_s(o_sum), 4);
    @(negedge clk);
    chk("t4_c_sum", sum_s(o_sum), 9);
    @(posedge clk); #1;
    idle(2);

    // Accumulator overflow.
    for (int i = 0; i < 20; i++) send_beat(pack4(-16384, -16384, -16384, -16384), i == 19);
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid", longint'(o_valid), 1);
`ifdef ACC_SAT_EN
    chk("t5_sum", sum_s(o_sum), -131072);
    chk("t5_ovf", longint'(o_ovf), 1);
`else
    chk("t5_sum", sum_s(o_sum), 0);
    chk("t5_ovf", longint'(o_ovf), 0);
`endif
    @(posedge clk); #1;
    idle(2);

    // Random groups with random output backpressure.
    rdy_rand = 1'b1;
    for (int g = 0; g < 40; g++) begin
      nb = int'($urandom_range(1, 16));
      for (int b = 0; b < nb; b++) begin
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (gap > 0) idle(gap);
        send_beat(pack4(int'($urandom_range(0, 32767)) - 16384,
                        int'($urandom_range(0, 32767)) - 16384,
                        int'($urandom_range(0, 32767)) - 16384,
                        int'($urandom_range(0, 32767)) - 16384), b == nb - 1);
      end
    end
    rdy_rand = 1'b0;
    i_ready  = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", longint'(q.size()), 0);
    chk("group_count", longint'(n_out), longint'(n_groups));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
